pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control block for the in-order RISC pipeline. It replaces the ad-hoc single-cycle load-use toggle at the processor top. It generates per-stage enable, flush and valid signals for an N-stage pipeline from three sources:
- load-use hazards, with a configurable stall depth;
- taken branches, with a configurable bubble count;
- a memory-wait handshake.

It also keeps stall and flush performance counters. It sits beside the forwarding unit and drives the enables of fetch, decode, execute, memory and writeback.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_hz_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// register-address width and the hazard FSM state encoding.
package pipe_hazard_ctrl_pkg;

  localparam int ADDR_WIDTH = 4;

  localparam int IF_IDX  = 0;
  localparam int ID_IDX  = 1;
  localparam int EX_IDX  = 2;
  localparam int MEM_IDX = 3;
  localparam int WB_IDX  = MEM_IDX + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_detect.sv
// Combinational load-use comparator: flags an ID source read of the register
// a valid load in EX is about to write. Register 0 never matches.
module hz_detect #(
  parameter int ADDR_WIDTH = pipe_hazard_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                  ex_valid,
  input  logic                  ex_is_ld,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard  = ex_valid && ex_is_ld && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage enable/flush/valid generation for the in-order pipeline from
// load-use hazards, taken branches and the memory wait handshake.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int ADDR_WIDTH = pipe_hazard_ctrl_pkg::ADDR_WIDTH,
  parameter int LD_LAT     = 1,
  parameter int BR_PENALTY = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_en,
  input  logic [ADDR_WIDTH-1:0]            id_rs1,
  input  logic [ADDR_WIDTH-1:0]            id_rs2,
  input  logic                             id_uses_rs1,
  input  logic                             id_uses_rs2,
  input  logic                             ex_is_ld,
  input  logic [ADDR_WIDTH-1:0]            ex_rd,
  input  logic                             branch_taken,
  input  logic                             mem_busy,
  output logic [NUM_STAGES-1:0]            stage_en,
  output logic [NUM_STAGES-1:0]            stage_flush,
  output logic [NUM_STAGES-1:0]            stage_valid,
  output logic                             ld_use_stall,
  output logic [CNT_WIDTH-1:0]             stall_cnt,
  output logic [CNT_WIDTH-1:0]             flush_cnt,
  output pipe_hazard_ctrl_pkg::hz_state_e  dbg_state
);

  import pipe_hazard_ctrl_pkg::*;

  localparam logic [2:0] LD_RELOAD = 3'(LD_LAT - 1);
  localparam logic [2:0] BR_RELOAD = 3'(BR_PENALTY - 1);

  hz_state_e             state, state_nxt;
  logic [2:0]            rem, rem_nxt;
  logic                  hazard;
  logic                  br_q;
  logic                  flush_inc;
  logic [NUM_STAGES-1:0] valid_in;

  hz_detect #(.ADDR_WIDTH(ADDR_WIDTH)) u_hz_detect (
    .ex_valid    (stage_valid[EX_IDX]),
    .ex_is_ld    (ex_is_ld),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard)
  );

  assign br_q      = branch_taken & stage_valid[EX_IDX];
  assign valid_in  = {stage_valid[NUM_STAGES-2:0], fetch_en};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // mem_busy is a wait handshake: while high, MEM's transfer has not completed
  // and everything up to MEM holds; the cycle it drops, MEM completes.
  always_comb begin : next_state
    state_nxt = state;
    rem_nxt   = rem;
    flush_inc = 1'b0;
    if (mem_busy) begin
      state_nxt = MEM_WAIT;
      rem_nxt   = '0;
    end else begin
      case (state)
        LD_STALL: begin
          rem_nxt = rem - 3'd1;
          if (rem == 3'd1) state_nxt = RUN;
        end
        BR_FLUSH: begin
          if (br_q) begin
            flush_inc = 1'b1;
            rem_nxt   = BR_RELOAD;
          end else begin
            rem_nxt = rem - 3'd1;
            if (rem == 3'd1) state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          rem_nxt   = '0;
          if (br_q) begin
            flush_inc = 1'b1;
            if (BR_PENALTY > 1) begin
              state_nxt = BR_FLUSH;
              rem_nxt   = BR_RELOAD;
            end
          end else if (hazard && (LD_LAT > 1)) begin
            state_nxt = LD_STALL;
            rem_nxt   = LD_RELOAD;
          end
        end
      endcase
    end
  end

  always_comb begin : outputs
    stage_en     = '1;
    stage_flush  = '0;
    ld_use_stall = 1'b0;
    if (!rst) begin
      stage_flush = '1;
    end else if (mem_busy) begin
      // Writeback keeps draining; a bubble follows the stuck MEM instruction.
      stage_en = '0;
      for (int i = WB_IDX; i < NUM_STAGES; i++) stage_en[i] = 1'b1;
      stage_flush[WB_IDX] = 1'b1;
    end else begin
      case (state)
        LD_STALL: begin
          stage_en[IF_IDX]    = 1'b0;
          stage_en[ID_IDX]    = 1'b0;
          stage_flush[EX_IDX] = 1'b1;
          ld_use_stall        = 1'b1;
        end
        BR_FLUSH: begin
          stage_flush[IF_IDX] = 1'b1;
          if (br_q) stage_flush[ID_IDX] = 1'b1;
        end
        default: begin
          if (br_q) begin
            stage_flush[IF_IDX] = 1'b1;
            stage_flush[ID_IDX] = 1'b1;
          end else if (hazard) begin
            stage_en[IF_IDX]    = 1'b0;
            stage_en[ID_IDX]    = 1'b0;
            stage_flush[EX_IDX] = 1'b1;
            ld_use_stall        = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (stage_en[i]) stage_valid[i] <= valid_in[i] & ~stage_flush[i];
      end
      if (ld_use_stall || (state == MEM_WAIT)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan steps followed by random
// traffic, every cycle compared against a remaining-penalty reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int NS = 6;
  localparam int AW = ADDR_WIDTH;
  localparam int LL = 2;
  localparam int BP = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_is_ld = 1'b0;
  logic          branch_taken = 1'b0, mem_busy = 1'b0;
  logic [NS-1:0] stage_en, stage_flush, stage_valid;
  logic          ld_use_stall;
  logic [CW-1:0] stall_cnt, flush_cnt;
  hz_state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining penalty cycles rather than an FSM.
  int            ld_left = 0, br_left = 0;
  bit            waiting = 1'b0;
  logic [NS-1:0] m_valid = '0;
  int            m_stall = 0, m_flush = 0;
  logic [NS-1:0] e_en, e_flush;
  logic          e_stall;
  bit            e_br;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .ADDR_WIDTH(AW), .LD_LAT(LL), .BR_PENALTY(BP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_ld(ex_is_ld), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stage_en(stage_en), .stage_flush(stage_flush), .stage_valid(stage_valid),
    .ld_use_stall(ld_use_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard_now();
    return m_valid[2] && ex_is_ld && (ex_rd != 0) &&
           ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
  endfunction

  function automatic hz_state_e model_state();
    if (waiting) return MEM_WAIT;
    if (ld_left > 0) return LD_STALL;
    if (br_left > 0) return BR_FLUSH;
    return RUN;
  endfunction

  task automatic model_outputs();
    e_en = '1; e_flush = '0; e_stall = 1'b0;
    e_br = branch_taken && m_valid[2];
    if (!rst) e_flush = '1;
    else if (mem_busy) begin
      e_en = '0;
      for (int i = 4; i < NS; i++) e_en[i] = 1'b1;
      e_flush[4] = 1'b1;
    end
    else if (ld_left > 0) begin e_en[1:0] = 2'b00; e_flush[2] = 1'b1; e_stall = 1'b1; end
    else if (e_br) e_flush[1:0] = 2'b11;
    else if (br_left > 0) e_flush[0] = 1'b1;
    else if (hazard_now()) begin e_en[1:0] = 2'b00; e_flush[2] = 1'b1; e_stall = 1'b1; end
  endtask

  task automatic model_update();
    logic [NS-1:0] prev, nv;
    if (!rst) begin
      ld_left = 0; br_left = 0; waiting = 1'b0; m_valid = '0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_stall || waiting) m_stall = (m_stall + 1) % (1 << CW);
      prev = {m_valid[NS-2:0], fetch_en};
      for (int i = 0; i < NS; i++) nv[i] = e_en[i] ? (prev[i] & ~e_flush[i]) : m_valid[i];
      if (mem_busy) begin
        waiting = 1'b1; ld_left = 0; br_left = 0;
      end else begin
        waiting = 1'b0;
        if (ld_left > 0) ld_left--;
        else if (e_br) begin m_flush = (m_flush + 1) % (1 << CW); br_left = BP - 1; end
        else if (br_left > 0) br_left--;
        else if (e_stall) ld_left = LL - 1;
      end
      m_valid = nv;
    end
  endtask

  // Inputs are set at the falling edge; comparisons happen 1 ns later.
  task automatic step();
    #1;
    model_outputs();
    chk("stage_en", 32'(stage_en), 32'(e_en));
    chk("stage_flush", 32'(stage_flush), 32'(e_flush));
    chk("ld_use_stall", 32'(ld_use_stall), 32'(e_stall));
    chk("stage_valid", 32'(stage_valid), 32'(m_valid));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("state", 32'(dbg_state), 32'(model_state()));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_ld = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic refill(input int n);
    clear_inputs();
    fetch_en = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic set_ld_hazard();
    ex_is_ld = 1'b1; ex_rd = AW'(5); id_rs1 = AW'(5); id_uses_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    do_reset();
    chk("reset_valid", 32'(stage_valid), 32'd0);

    // Load-use stall of LD_LAT cycles
    refill(3);
    set_ld_hazard();
    step();
    clear_inputs();
    step();
    chk("tp_ld_ex_bubble", 32'(stage_valid[2]), 32'd0);
    chk("tp_ld_stall_cnt", 32'(stall_cnt), 32'd2);

    // Register 0 and unused source never stall
    refill(3);
    ex_is_ld = 1'b1; ex_rd = '0; id_rs2 = '0; id_uses_rs2 = 1'b1;
    step();
    ex_is_ld = 1'b1; ex_rd = AW'(7); id_rs1 = AW'(7); id_uses_rs1 = 1'b0;
    step();
    chk("tp_no_hazard_cnt", 32'(stall_cnt), 32'd2);

    // Taken branch, then a second branch inside the flush window
    do_reset();
    refill(4);
    branch_taken = 1'b1;
    step();
    step();
    clear_inputs();
    repeat (3) step();
    chk("tp_br_flush_cnt", 32'(flush_cnt), 32'd2);

    // Memory wait preempting a load-use stall
    do_reset();
    refill(4);
    set_ld_hazard();
    step();
    clear_inputs();
    mem_busy = 1'b1;
    repeat (4) step();
    mem_busy = 1'b0;
    step();
    chk("tp_mem_stall_cnt", 32'(stall_cnt), 32'd5);
    refill(2);

    // Branch and hazard in the same cycle: flush only
    refill(3);
    set_ld_hazard();
    branch_taken = 1'b1;
    #1 chk("tp_br_hz_nostall", 32'(ld_use_stall), 32'd0);
    step();
    clear_inputs();
    repeat (3) step();

    // Reset in the middle of a load-use stall
    refill(3);
    set_ld_hazard();
    step();
    do_reset();
    chk("tp_rst_valid", 32'(stage_valid), 32'd0);
    chk("tp_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("tp_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("tp_rst_state", 32'(dbg_state), 32'(RUN));

    // 17 stall cycles wrap a 4-bit counter to 1
    mem_busy = 1'b1;
    repeat (17) step();
    mem_busy = 1'b0;
    step();
    chk("tp_wrap_stall_cnt", 32'(stall_cnt), 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 49) != 0);
      fetch_en     = ($urandom_range(0, 9) != 0);
      id_rs1       = AW'($urandom_range(0, 3));
      id_rs2       = AW'($urandom_range(0, 3));
      ex_rd        = AW'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      ex_is_ld     = ($urandom_range(0, 9) < 4);
      branch_taken = ($urandom_range(0, 99) < 15);
      mem_busy     = ($urandom_range(0, 99) < 10);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
